// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Time-multiplexed FIR controller acting as operand initiator for a shared,
//   combinational MAC (mac_out = mac_a*mac_b + mac_c). Each accepted sample is
//   written into a circular history. NTAPS taps are then fed to the MAC, one
//   per cycle, with the running accumulator looped back on mac_c. The 48-bit
//   sum is rounded half-up, shifted right by SHIFT, and then clipped (or wrapped)
//   to OUT_W bits. The result is presented on a valid/ready handshake.
//
//   Optional build macro: FIR_SEQ_SAT_EN
//     defined   -> result saturates to OUT_W range, sat_flag reports clipping
//     undefined -> result wraps to its low OUT_W bits, sat_flag is always 0
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_data/valid/ready   sample input handshake
//   coef_we/addr/data     coefficient RAM write port (honoured in IDLE only)
//   mac_a/b/c, mac_out    operands to / result from the shared MAC
//   out_data/valid/ready  filtered sample output handshake
//   sat_flag              out_data was clipped (qualified by out_valid)
module fir_mac_sequencer #(
  parameter int NTAPS  = 32,
  parameter int DATA_W = 24,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 17,
  localparam int AW    = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [17:0]       coef_data,
  output logic [24:0]       mac_a,
  output logic [17:0]       mac_b,
  output logic [47:0]       mac_c,
  input  logic [47:0]       mac_out,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_flag
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_OUTPUT = 3'd4;

  localparam logic [AW-1:0]     LAST = AW'(NTAPS - 1);
  localparam logic signed [47:0] HALF = 48'sd1 <<< (SHIFT - 1);

  logic [2:0]               state;
  logic [AW-1:0]            wr_ptr, rd_ptr, tap;
  logic signed [47:0]       acc;
  logic signed [DATA_W-1:0] hist [NTAPS];
  logic signed [17:0]       coef [NTAPS];

  logic          accept;
  logic [AW-1:0] wr_next, rd_prev;

  assign accept  = (state == S_IDLE) && in_valid && in_ready;
  // Explicit wrap so NTAPS need not be a power of two.
  assign wr_next = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign rd_prev = (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;

  // MAC operands are driven only while accumulating; zero otherwise so they
  // sit at their reset value until the first tap is issued.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    if (state == S_ACCUM) begin
      mac_a = 25'(hist[rd_ptr]);
      mac_b = coef[tap];
      mac_c = acc;
    end
  end

  // Round half-up then arithmetic shift, all at 48 bits.
  logic signed [47:0]  rsum, rsh;
  logic [OUT_W-1:0]    rnd_data;
  logic                rnd_sat;

  assign rsum = acc + HALF;
  assign rsh  = rsum >>> SHIFT;

`ifdef FIR_SEQ_SAT_EN
  localparam logic signed [47:0] OMAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
  localparam logic signed [47:0] OMIN = -(48'sd1 <<< (OUT_W - 1));

  always_comb begin
    rnd_data = rsh[OUT_W-1:0];
    rnd_sat  = 1'b0;
    if (rsh > OMAX) begin
      rnd_data = OMAX[OUT_W-1:0];
      rnd_sat  = 1'b1;
    end else if (rsh < OMIN) begin
      rnd_data = OMIN[OUT_W-1:0];
      rnd_sat  = 1'b1;
    end
  end
`else
  // Two's-complement wrap: upper bits are deliberately discarded.
  logic unused_rnd_hi;
  assign unused_rnd_hi = ^rsh[47:OUT_W];
  assign rnd_data      = rsh[OUT_W-1:0];
  assign rnd_sat       = 1'b0;
`endif

  // History: cleared entry-by-entry in CLEAR, written on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR)
        hist[tap] <= '0;
      else if (accept)
        hist[wr_next] <= $signed(in_data);
    end
  end

  // Coefficient RAM has no reset; writes only land between samples.
  always_ff @(posedge clk) begin
    if (!rst && coef_we && (state == S_IDLE))
      coef[coef_addr] <= $signed(coef_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      acc       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tap       <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          tap <= tap + 1'b1;
          if (tap == LAST) begin
            tap      <= '0;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (accept) begin
            wr_ptr   <= wr_next;
            rd_ptr   <= wr_next;   // tap 0 reads the newest sample
            acc      <= '0;
            tap      <= '0;
            in_ready <= 1'b0;
            state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc    <= $signed(mac_out);
          rd_ptr <= rd_prev;
          tap    <= tap + 1'b1;
          if (tap == LAST) begin
            tap   <= '0;
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          out_data  <= rnd_data;
          sat_flag  <= rnd_sat;
          out_valid <= 1'b1;
          state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;
  localparam int NTAPS  = 32;
  localparam int DATA_W = 24;
  localparam int OUT_W  = 24;
  localparam int SHIFT  = 17;
  localparam int AW     = $clog2(NTAPS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [17:0]       coef_data = '0;
  logic [24:0]       mac_a;
  logic [17:0]       mac_b;
  logic [47:0]       mac_c;
  logic [47:0]       mac_out;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              sat_flag;

  fir_mac_sequencer #(.NTAPS(NTAPS), .DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_out(mac_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Shared MAC: combinational a*b+c at 48 bits.
  logic signed [47:0] ea, eb;
  assign ea      = $signed(mac_a);
  assign eb      = $signed(mac_b);
  assign mac_out = ea * eb + $signed(mac_c);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: newest-first sample list and coefficient table.
  longint xq[$];
  longint hm[NTAPS];
  logic [OUT_W-1:0] last_d;
  logic             last_s;

  task automatic model_clear();
    xq.delete();
    for (int i = 0; i < NTAPS; i++) xq.push_back(0);
  endtask

  task automatic model_push(input int s);
    xq.push_front(longint'(s));
    void'(xq.pop_back());
  endtask

  task automatic model_eval(output logic [OUT_W-1:0] d, output logic s);
    longint acc, r, mx, mn;
    acc = 0;
    for (int k = 0; k < NTAPS; k++) acc += hm[k] * xq[k];
    r  = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    mx = (longint'(1) << (OUT_W - 1)) - 1;
    mn = -(longint'(1) << (OUT_W - 1));
    d  = r[OUT_W-1:0];
    s  = 1'b0;
`ifdef FIR_SEQ_SAT_EN
    if (r > mx) begin d = mx[OUT_W-1:0]; s = 1'b1; end
    else if (r < mn) begin d = mn[OUT_W-1:0]; s = 1'b1; end
`else
    if (r > mx || r < mn) s = 1'b0;
`endif
  endtask

  // All tasks start and end just after a negedge.
  task automatic write_coef(input int k, input int v);
    coef_we   = 1'b1;
    coef_addr = k[AW-1:0];
    coef_data = v[17:0];
    @(posedge clk); @(negedge clk);
    coef_we   = 1'b0;
    hm[k]     = longint'(v);
  endtask

  // Pulse reset for n edges, then count cycles until in_ready rises.
  task automatic do_reset(input int n, output int cnt, output bit ov_seen);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cnt = 0; ov_seen = 1'b0;
    while (!in_ready && cnt < 200) begin
      @(posedge clk); @(negedge clk);
      cnt++;
      if (out_valid) ov_seen = 1'b1;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); @(negedge clk); n++; end
    chk({tag, " in_ready"}, longint'(in_ready), 1);
  endtask

  task automatic run_sample(input int s, input int hold, input string tag);
    int n;
    logic [OUT_W-1:0] ed;
    logic es;
    wait_ready(tag);
    in_data  = s[DATA_W-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    model_push(s);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    chk({tag, " latency"}, n, NTAPS + 1);
    model_eval(ed, es);
    chk({tag, " data"}, longint'(out_data), longint'(ed));
    chk({tag, " sat"}, longint'(sat_flag), longint'(es));
    last_d = out_data;
    last_s = sat_flag;
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      chk({tag, " hold"}, longint'({out_valid, out_data}), longint'({1'b1, ed}));
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drop"}, longint'({out_valid, in_ready}), 2'b01);
  endtask

  typedef struct {
    int               smp;
    logic [OUT_W-1:0] exp;
  } rvec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rvec_t rt[6];
    int cnt;
    bit ovs;
    int n;
    logic [OUT_W-1:0] ed;
    logic es;

    rt[0] = '{65536,   24'h000001};
    rt[1] = '{65535,   24'h000000};
    rt[2] = '{-65536,  24'h000000};
    rt[3] = '{-65537,  24'hFFFFFF};
    rt[4] = '{196608,  24'h000002};
    rt[5] = '{-196609, 24'hFFFFFE};
    for (int k = 0; k < NTAPS; k++) hm[k] = 0;

    // Reset values, then CLEAR duration.
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset outs", longint'({in_ready, out_valid, sat_flag}), 0);
    chk("reset out_data", longint'(out_data), 0);
    chk("reset mac", longint'(mac_a) | longint'(mac_b) | longint'(mac_c), 0);
    rst = 1'b0;
    model_clear();
    cnt = 0; ovs = 1'b0;
    while (!in_ready && cnt < 200) begin
      @(posedge clk); @(negedge clk); cnt++;
      if (out_valid || mac_a != 0 || mac_c != 0) ovs = 1'b1;
    end
    chk("clear length", cnt, NTAPS);
    chk("clear quiet", longint'(ovs), 0);

    // Impulse response with h[k]=k+1.
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    for (int k = 0; k < NTAPS; k++) begin
      run_sample((k == 0) ? 131072 : 0, 0, "impulse");
      chk("impulse value", longint'(last_d), k + 1);
    end

    // Rounding table, each after a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset(2, cnt, ovs);
      chk("round clear", cnt, NTAPS);
      if (i == 0) for (int k = 0; k < NTAPS; k++) write_coef(k, (k == 0) ? 1 : 0);
      run_sample(rt[i].smp, 0, "round");
      chk("round value", longint'(last_d), longint'(rt[i].exp));
    end

    // Saturation / wrap extremes.
    do_reset(2, cnt, ovs);
    for (int k = 0; k < NTAPS; k++) write_coef(k, 131071);
    for (int k = 0; k < NTAPS; k++) run_sample(32'h007FFFFF, 0, "satpos");
`ifdef FIR_SEQ_SAT_EN
    chk("satpos final", longint'({last_s, last_d}), longint'({1'b1, 24'h7FFFFF}));
`else
    chk("wrappos final", longint'({last_s, last_d}), longint'({1'b0, 24'hFFF7E0}));
`endif
    for (int k = 0; k < NTAPS; k++) run_sample(-8388608, 0, "satneg");
`ifdef FIR_SEQ_SAT_EN
    chk("satneg final", longint'({last_s, last_d}), longint'({1'b1, 24'h800000}));
`else
    chk("wrapneg final", longint'({last_s, last_d}), longint'({1'b0, 24'h000800}));
`endif

    // Randomized coefficients, samples and backpressure against the model.
    for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 262143)) - 131072);
    for (int i = 0; i < 40; i++) begin
      int s;
      if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, 2047)) - 1024;
      else s = int'($urandom_range(0, 16777215)) - 8388608;
      run_sample(s, int'($urandom_range(0, 3)), "random");
    end

    // Backpressure: hold 10 cycles, stray in_valid must be ignored.
    wait_ready("bp");
    in_data = 24'h012345; in_valid = 1'b1;
    @(posedge clk);
    model_push(32'h00012345);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); @(negedge clk); n++; end
    model_eval(ed, es);
    chk("bp data", longint'(out_data), longint'(ed));
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin in_data = 24'h7ABCDE; in_valid = 1'b1; end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      chk("bp stable", longint'({out_valid, in_ready, out_data}), longint'({2'b10, ed}));
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("bp release", longint'({out_valid, in_ready}), 2'b01);
    run_sample(1000, 0, "bp next");

    // Reset at ACCUM tap 10: no output, full re-clear, no stale history.
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    wait_ready("abort");
    in_data = 24'h003039; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    ovs = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); if (out_valid) ovs = 1'b1; end
    chk("abort pre", longint'(ovs), 0);
    do_reset(1, cnt, ovs);
    chk("abort clear", cnt, NTAPS);
    chk("abort no output", longint'(ovs), 0);
    run_sample(131072, 0, "abort imp");
    chk("abort first", longint'(last_d), 1);
    run_sample(0, 0, "abort imp");
    chk("abort second", longint'(last_d), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
